// File: rtl/interleaver_pkg.sv
// Shared constants and types for the ping-pong interleaver controller.
// Default configuration: 192 coded bits per symbol, QPSK, 16 columns.
package interleaver_pkg;

    localparam int NCBPS = 192;                               // bank depth
    localparam int NCPC  = 2;                                 // coded bits per carrier
    localparam int D     = 16;                                // interleaver columns
    localparam int S     = (NCPC / 2 > 1) ? (NCPC / 2) : 1;   // rotation parameter
    localparam int AW    = $clog2(NCBPS);

    typedef logic [AW-1:0] addr_t;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_t;

endpackage

// File: rtl/interleaver_pingpong_ctrl_if.sv
// Handshake and memory-control bundle between the controller (master)
// and its surroundings: encoder side, bank RAMs and the mapper.
interface interleaver_pingpong_ctrl_if;

    import interleaver_pkg::*;

    logic  valid_in;
    logic  ready_out;
    logic  wr_en;
    logic  wr_bank;
    addr_t wr_addr;
    logic  rd_en;
    logic  rd_bank;
    addr_t rd_addr;
    logic  valid_out;
    logic  ready_in;
    addr_t data_out_index;
    logic  block_done;

    modport master (
        input  valid_in, ready_in,
        output ready_out, wr_en, wr_bank, wr_addr,
               rd_en, rd_bank, rd_addr,
               valid_out, data_out_index, block_done
    );

    modport slave (
        output valid_in, ready_in,
        input  ready_out, wr_en, wr_bank, wr_addr,
               rd_en, rd_bank, rd_addr,
               valid_out, data_out_index, block_done
    );

endinterface

// File: rtl/interleaver_addr_gen.sv
// Combinational two-step 802.16 block-interleaver permutation k -> j.
// Evaluated in 32-bit integers so d*m cannot overflow the address width.
module interleaver_addr_gen
    import interleaver_pkg::*;
(
    input  addr_t k,
    output addr_t j
);

    int m;
    int j_full;

    // First permutation spreads adjacent bits across columns; second rotates
    // within groups of S so bits alternate between constellation significance.
    always_comb begin
        m      = (NCBPS / D) * (int'(k) % D) + int'(k) / D;
        j_full = S * (m / S) + ((m + NCBPS - (D * m) / NCBPS) % S);
        j      = addr_t'(j_full);
    end

endmodule

// File: rtl/interleaver_pingpong_ctrl.sv
// Ping-pong interleaver controller: fills one bank at permuted addresses
// while draining the other in natural order through a one-deep output
// register that tracks the synchronous RAM's one-cycle read latency.
module interleaver_pingpong_ctrl
    import interleaver_pkg::*;
(
    input  logic                               clk,
    input  logic                               reset,
    interleaver_pingpong_ctrl_if.master        bus
);

    localparam addr_t LAST = addr_t'(NCBPS - 1);

    bank_state_t bank_q [2];
    bank_state_t bank_d [2];
    logic        wr_bank_q, wr_bank_d;
    logic        rd_bank_q, rd_bank_d;
    addr_t       k_q, k_d;
    addr_t       r_q, r_d;
    addr_t       idx_q, idx_d;
    logic        valid_q, valid_d;

    logic        ready_out;
    logic        wr_en;
    logic        rd_en;
    addr_t       perm_addr;

    interleaver_addr_gen u_addr_gen (
        .k (k_q),
        .j (perm_addr)
    );

    // Handshake strobes; all derived from registered bank state so a bank
    // freed this cycle only becomes writable next cycle.
    always_comb begin
        ready_out = !reset && ((bank_q[wr_bank_q] == EMPTY) ||
                               (bank_q[wr_bank_q] == FILLING));
        wr_en     = bus.valid_in && ready_out;
        rd_en     = !reset && ((bank_q[rd_bank_q] == FULL) ||
                               (bank_q[rd_bank_q] == DRAINING)) &&
                    (!valid_q || bus.ready_in);
    end

    // Next-state for bank FSMs, pointers and the output register.
    // The writer only touches EMPTY/FILLING banks and the reader only
    // FULL/DRAINING ones, so the two updates never collide on one bank.
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves it
        // unassigned, which would otherwise infer a latch.
        bank_d    = bank_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        k_d       = k_q;
        r_d       = r_q;
        idx_d     = idx_q;
        valid_d   = valid_q && !bus.ready_in;

        if (wr_en) begin
            if (k_q == LAST) begin
                k_d               = '0;
                wr_bank_d         = !wr_bank_q;
                bank_d[wr_bank_q] = FULL;
            end else begin
                k_d               = k_q + addr_t'(1);
                bank_d[wr_bank_q] = FILLING;
            end
        end

        if (rd_en) begin
            idx_d   = r_q;
            valid_d = 1'b1;
            if (r_q == LAST) begin
                r_d               = '0;
                rd_bank_d         = !rd_bank_q;
                bank_d[rd_bank_q] = EMPTY;
            end else begin
                r_d               = r_q + addr_t'(1);
                bank_d[rd_bank_q] = DRAINING;
            end
        end
    end

    // State register; synchronous reset discards both banks and the held bit.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            bank_q[0] <= EMPTY;
            bank_q[1] <= EMPTY;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            k_q       <= '0;
            r_q       <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            bank_q    <= bank_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            k_q       <= k_d;
            r_q       <= r_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.ready_out      = ready_out;
    assign bus.wr_en          = wr_en;
    assign bus.wr_bank        = wr_bank_q;
    assign bus.wr_addr        = perm_addr;
    assign bus.rd_en          = rd_en;
    assign bus.rd_bank        = rd_bank_q;
    assign bus.rd_addr        = r_q;
    assign bus.valid_out      = valid_q;
    assign bus.data_out_index = idx_q;
    assign bus.block_done     = valid_q && bus.ready_in && (idx_q == LAST);

endmodule

// File: tb/tb_interleaver_pingpong_ctrl.sv
// Scoreboard bench for interleaver_pingpong_ctrl. A behavioural two-bank
// 1-bit RAM plus output register surround the controller; expected output
// bits come from the published golden input/output vector pair.
module tb_interleaver_pingpong_ctrl;

    import interleaver_pkg::*;

    localparam addr_t LAST = addr_t'(NCBPS - 1);

    typedef struct packed {
        addr_t idx;
        logic  bit_v;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic din;
    logic data_reg;
    logic [NCBPS-1:0] mem [2];

    logic [NCBPS-1:0] gold_in  = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;
    logic [NCBPS-1:0] gold_out = 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E;

    int map_k [5] = '{0, 1, 15, 16, 191};
    int map_j [5] = '{0, 12, 180, 1, 191};

    int   cyc = 0;
    int   base = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_sent = 0;
    int   stalls = 0;
    int   first_rd_en, first_valid, last_done, done_count, ready_rise, idx_moved;
    int   rel;
    logic hold_watch = 1'b0;
    logic watch_ready = 1'b0;
    exp_t exp_q [$];

    interleaver_pingpong_ctrl_if bus ();

    interleaver_pingpong_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bank RAMs with one-cycle read latency into the output data register.
    always @(posedge clk) begin
        if (bus.wr_en === 1'b1) mem[bus.wr_bank][bus.wr_addr] <= din;
        if (bus.rd_en === 1'b1) data_reg <= mem[bus.rd_bank][bus.rd_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic clear_log();
        first_rd_en = -1;
        first_valid = -1;
        last_done   = -1;
        done_count  = 0;
        ready_rise  = -1;
        idx_moved   = 0;
    endtask

    task automatic push_blocks(input int n);
        exp_t e;
        for (int b = 0; b < n; b++) begin
            for (int j = 0; j < NCBPS; j++) begin
                e.idx   = addr_t'(j);
                e.bit_v = gold_out[NCBPS - 1 - j];
                exp_q.push_back(e);
            end
        end
    endtask

    // Offers 'total' bits of the golden input stream, holding each bit until
    // accepted; base marks the cycle valid_in is first raised.
    task automatic send_bits(input int total, input int budget);
        int sent  = 0;
        int spent = 0;
        stalls = 0;
        n_sent = 0;
        forever begin
            @(negedge clk);
            if (sent >= total) begin
                bus.valid_in = 1'b0;
                break;
            end
            if (spent >= budget) begin
                bus.valid_in = 1'b0;
                check("send budget", sent, total);
                break;
            end
            if (spent == 0) base = cyc;
            bus.valid_in = 1'b1;
            din = gold_in[NCBPS - 1 - (sent % NCBPS)];
            #1;
            if (bus.ready_out === 1'b1) begin
                for (int i = 0; i < 5; i++)
                    if ((sent % NCBPS) == map_k[i]) check("wr_addr map", bus.wr_addr, map_j[i]);
                sent++;
                n_sent = sent;
            end else begin
                stalls++;
            end
            spent++;
        end
    endtask

    task automatic wait_drain(input int budget);
        int spent = 0;
        while (exp_q.size() != 0 && spent < budget) begin
            @(negedge clk);
            #2;
            spent++;
        end
        check("drain in budget", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_log();
    endtask

    // Event logger: records absolute cycles of key DUT events.
    always begin
        @(negedge clk);
        #1;
        if (bus.rd_en === 1'b1 && first_rd_en < 0) first_rd_en = cyc;
        if (bus.valid_out === 1'b1 && first_valid < 0) first_valid = cyc;
        if (bus.block_done === 1'b1) begin
            last_done = cyc;
            done_count++;
        end
        if (hold_watch && bus.valid_out === 1'b1 && bus.data_out_index != '0) idx_moved++;
        if (watch_ready && bus.ready_out === 1'b1 && ready_rise < 0) ready_rise = cyc;
    end

    // Scoreboard monitor: compares every accepted output against the queue.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (bus.valid_out === 1'b1 && bus.ready_in === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected output", bus.valid_out, 0);
            end else begin
                e = exp_q.pop_front();
                check("out index", bus.data_out_index, e.idx);
                check("out bit", data_reg, e.bit_v);
                check("block_done", bus.block_done, (e.idx == LAST));
            end
        end else if (bus.block_done !== 1'b0) begin
            check("stray block_done", bus.block_done, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_log();
        reset        = 1'b1;
        bus.valid_in = 1'b1;
        bus.ready_in = 1'b0;
        din          = 1'b0;

        // Reset holds every output low even with valid_in asserted.
        @(negedge clk);
        #2;
        check("rst ready_out", bus.ready_out, 0);
        check("rst wr_en", bus.wr_en, 0);
        check("rst rd_en", bus.rd_en, 0);
        check("rst valid_out", bus.valid_out, 0);
        @(negedge clk);
        reset        = 1'b0;
        bus.valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("idle ready_out", bus.ready_out, 1);
            check("idle valid_out", bus.valid_out, 0);
            check("idle wr_bank", bus.wr_bank, 0);
            check("idle rd_en", bus.rd_en, 0);
            @(negedge clk);
        end

        // Single block, no backpressure: latency and address map.
        do_reset();
        bus.ready_in = 1'b1;
        push_blocks(1);
        send_bits(NCBPS, 1000);
        wait_drain(1000);
        check("1blk first rd_en", first_rd_en - base, 192);
        check("1blk first valid", first_valid - base, 193);
        check("1blk block_done", last_done - base, 384);
        check("1blk done count", done_count, 1);

        // Five back-to-back blocks: no write stalls, no output bubbles.
        do_reset();
        bus.ready_in = 1'b1;
        push_blocks(5);
        send_bits(5 * NCBPS, 3000);
        check("5blk write stalls", stalls, 0);
        wait_drain(2000);
        check("5blk first valid", first_valid - base, 193);
        check("5blk last done", last_done - base, 1152);
        check("5blk done count", done_count, 5);

        // Backpressure: two banks fill, writer stalls, output bit held.
        do_reset();
        hold_watch = 1'b1;
        push_blocks(3);
        fork
            send_bits(3 * NCBPS, 3000);
        join_none
        @(negedge clk);
        #2;
        while (cyc - base < 450) begin
            @(negedge clk);
            #2;
        end
        check("bp writes accepted", n_sent, 2 * NCBPS);
        check("bp ready_out low", bus.ready_out, 0);
        check("bp valid_out held", bus.valid_out, 1);
        check("bp index held", bus.data_out_index, 0);
        check("bp index stable", idx_moved, 0);
        check("bp first valid", first_valid - base, 193);
        @(negedge clk);
        hold_watch   = 1'b0;
        bus.ready_in = 1'b1;
        rel          = cyc;
        watch_ready  = 1'b1;
        wait_drain(3000);
        check("bp ready_out rise", ready_rise - rel, 191);
        check("bp done count", done_count, 3);
        watch_ready = 1'b0;

        // Reset part-way through a block, then a clean block.
        do_reset();
        bus.ready_in = 1'b1;
        send_bits(100, 500);
        reset        = 1'b1;
        bus.valid_in = 1'b1;
        @(negedge clk);
        #2;
        check("mid rst ready_out", bus.ready_out, 0);
        check("mid rst wr_en", bus.wr_en, 0);
        check("mid rst wr_addr", bus.wr_addr, 0);
        check("mid rst wr_bank", bus.wr_bank, 0);
        check("mid rst rd_en", bus.rd_en, 0);
        check("mid rst valid_out", bus.valid_out, 0);
        @(negedge clk);
        reset        = 1'b0;
        bus.valid_in = 1'b0;
        #2;
        check("post rst ready_out", bus.ready_out, 1);
        check("post rst rd_addr", bus.rd_addr, 0);
        clear_log();
        push_blocks(1);
        send_bits(NCBPS, 1000);
        wait_drain(1000);
        check("post rst first valid", first_valid - base, 193);
        check("post rst done count", done_count, 1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
